// File: rtl/vend_seq_ctrl.sv
// vend_seq_ctrl: vending transaction sequencer.
// Holds three item prices and the coin credit, arbitrates cancel / select /
// configure / coin in IDLE, drops the product in a one-cycle VEND state, then
// pays the remaining credit back one greedy coin (50/10/5/1) per handshake.
module vend_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_idx,
    input  logic [7:0] cfg_price,
    output logic       cfg_ready,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    output logic       coin_reject,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    output logic       prod_valid,
    output logic [1:0] prod_id,
    output logic       err_insuff,
    output logic       chg_valid,
    output logic [1:0] chg_coin,
    input  logic       chg_ready,
    output logic [7:0] credit,
    output logic       busy
);

    localparam int unsigned CRED_W  = 8;
    localparam int unsigned SUM_W   = CRED_W + 1;
    localparam int unsigned CODE_W  = 2;
    localparam int unsigned ITEM_W  = 2;
    localparam int unsigned N_ITEMS = 3;

    localparam logic [CRED_W-1:0] DEN_1  = CRED_W'(1);
    localparam logic [CRED_W-1:0] DEN_5  = CRED_W'(5);
    localparam logic [CRED_W-1:0] DEN_10 = CRED_W'(10);
    localparam logic [CRED_W-1:0] DEN_50 = CRED_W'(50);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CRED_W-1:0]   r_credit;
    logic [CRED_W-1:0]   r_price [N_ITEMS];
    logic [ITEM_W-1:0]   r_item;
    logic                r_coin_rej;
    logic                r_err;

    logic                w_idle;
    logic                w_cfg_ready;
    logic                w_cancel_acc;
    logic                w_sel_req;
    logic                w_sel_acc;
    logic                w_sel_ref;
    logic                w_cfg_wr;
    logic                w_coin_acc;
    logic                w_coin_rej;
    logic                w_chg_take;
    logic                w_chg_last;
    logic [CRED_W-1:0]   w_sel_price;
    logic [CRED_W-1:0]   w_item_price;
    logic [CRED_W-1:0]   w_coin_val;
    logic [CRED_W-1:0]   w_vend_credit;
    logic [CRED_W-1:0]   w_chg_val;
    logic [CODE_W-1:0]   w_chg_code;
    logic [SUM_W-1:0]    w_coin_sum;

    // Price lookup for the requested selection and for the latched item.
    always_comb begin
        w_sel_price  = '0;
        w_item_price = '0;
        case (sel)
            2'd1:    w_sel_price = r_price[0];
            2'd2:    w_sel_price = r_price[1];
            2'd3:    w_sel_price = r_price[2];
            default: w_sel_price = '0;
        endcase
        case (r_item)
            2'd1:    w_item_price = r_price[0];
            2'd2:    w_item_price = r_price[1];
            2'd3:    w_item_price = r_price[2];
            default: w_item_price = '0;
        endcase
    end

    // Inserted coin value and greedy payout denomination from registered credit.
    always_comb begin
        w_coin_val = DEN_1;
        case (coin_code)
            2'd0:    w_coin_val = DEN_1;
            2'd1:    w_coin_val = DEN_5;
            2'd2:    w_coin_val = DEN_10;
            default: w_coin_val = DEN_50;
        endcase
        w_chg_val  = DEN_1;
        w_chg_code = CODE_W'(0);
        if (r_credit >= DEN_50) begin
            w_chg_val  = DEN_50;
            w_chg_code = CODE_W'(3);
        end else if (r_credit >= DEN_10) begin
            w_chg_val  = DEN_10;
            w_chg_code = CODE_W'(2);
        end else if (r_credit >= DEN_5) begin
            w_chg_val  = DEN_5;
            w_chg_code = CODE_W'(1);
        end
    end

    // IDLE arbitration: accepted cancel beats selection; a coin is refused when
    // either of those is taken or when it would overflow the credit register.
    assign w_idle        = (r_state == S_IDLE);
    assign w_cfg_ready   = w_idle && (r_credit == '0);
    assign w_cancel_acc  = w_idle && cancel && (r_credit != '0);
    assign w_sel_req     = w_idle && !w_cancel_acc && sel_valid && (sel != 2'd0);
    assign w_sel_acc     = w_sel_req && (w_sel_price != '0) && (r_credit >= w_sel_price);
    assign w_sel_ref     = w_sel_req && !w_sel_acc;
    assign w_cfg_wr      = cfg_valid && w_cfg_ready && (cfg_idx != 2'd3);
    assign w_coin_sum    = SUM_W'(r_credit) + SUM_W'(w_coin_val);
    assign w_coin_acc    = coin_valid && w_idle && !w_cancel_acc && !w_sel_acc
                           && !w_coin_sum[CRED_W];
    assign w_coin_rej    = coin_valid && !w_coin_acc;
    assign w_vend_credit = r_credit - w_item_price;
    assign w_chg_take    = (r_state == S_CHANGE) && chg_ready;
    assign w_chg_last    = w_chg_take && (r_credit <= w_chg_val);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cancel_acc) begin
                    w_next = S_CHANGE;
                end else if (w_sel_acc) begin
                    w_next = S_VEND;
                end
            end
            S_VEND: begin
                w_next = (w_vend_credit != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (w_chg_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Credit, price table, latched item and one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit   <= '0;
            r_price[0] <= '0;
            r_price[1] <= '0;
            r_price[2] <= '0;
            r_item     <= '0;
            r_coin_rej <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_coin_rej <= w_coin_rej;
            r_err      <= w_sel_ref;
            if (w_sel_acc) begin
                r_item <= sel;
            end
            if (w_cfg_wr) begin
                case (cfg_idx)
                    2'd0:    r_price[0] <= cfg_price;
                    2'd1:    r_price[1] <= cfg_price;
                    2'd2:    r_price[2] <= cfg_price;
                    default: ;
                endcase
            end
            case (r_state)
                S_IDLE: begin
                    if (w_coin_acc) begin
                        r_credit <= w_coin_sum[CRED_W-1:0];
                    end
                end
                S_VEND: begin
                    r_credit <= w_vend_credit;
                end
                S_CHANGE: begin
                    if (w_chg_take) begin
                        r_credit <= w_chg_last ? '0 : (r_credit - w_chg_val);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state; payloads read 0 when not valid.
    always_comb begin
        cfg_ready   = w_cfg_ready;
        coin_reject = r_coin_rej;
        err_insuff  = r_err;
        credit      = r_credit;
        prod_valid  = 1'b0;
        prod_id     = '0;
        chg_valid   = 1'b0;
        chg_coin    = '0;
        busy        = 1'b0;
        case (r_state)
            S_VEND: begin
                prod_valid = 1'b1;
                prod_id    = r_item;
                busy       = 1'b1;
            end
            S_CHANGE: begin
                chg_valid = 1'b1;
                chg_coin  = w_chg_code;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Bench for vend_seq_ctrl: directed vector table, an async-reset sequence,
// then random traffic checked against a transaction-level model.
module tb_vend_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_price;
    logic       cfg_ready;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       coin_reject;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       prod_valid;
    logic [1:0] prod_id;
    logic       err_insuff;
    logic       chg_valid;
    logic [1:0] chg_coin;
    logic       chg_ready;
    logic [7:0] credit;
    logic       busy;

    vend_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_price(cfg_price), .cfg_ready(cfg_ready),
        .coin_valid(coin_valid), .coin_code(coin_code), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .prod_valid(prod_valid), .prod_id(prod_id), .err_insuff(err_insuff),
        .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
        .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cfg_ready;
        logic       coin_reject;
        logic       prod_valid;
        logic [1:0] prod_id;
        logic       err_insuff;
        logic       chg_valid;
        logic [1:0] chg_coin;
        logic       busy;
        logic [7:0] credit;
    } outs_t;

    typedef struct {
        logic       cfgv;
        logic [1:0] idx;
        logic [7:0] price;
        logic       coinv;
        logic [1:0] code;
        logic       selv;
        logic [1:0] s;
        logic       cnl;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    localparam int M_IDLE = 0, M_VEND = 1, M_CHANGE = 2;
    int denom[4] = '{1, 5, 10, 50};
    int m_mode, m_credit, m_item;
    int m_price[3];
    bit m_rej, m_err;
    int m_pay[$];

    function automatic string fmt(input outs_t o);
        return $sformatf("rdy=%0d rej=%0d pv=%0d pid=%0d err=%0d cv=%0d coin=%0d busy=%0d credit=%0d",
                         o.cfg_ready, o.coin_reject, o.prod_valid, o.prod_id, o.err_insuff,
                         o.chg_valid, o.chg_coin, o.busy, o.credit);
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.cfg_ready = cfg_ready;   o.coin_reject = coin_reject;
        o.prod_valid = prod_valid; o.prod_id = prod_id;
        o.err_insuff = err_insuff; o.chg_valid = chg_valid;
        o.chg_coin = chg_coin;     o.busy = busy;
        o.credit = credit;
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t got;
        got = sample();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {%s} required {%s}", name, fmt(got), fmt(exp));
        end
    endtask

    // Expected-output builders: idle, vending, paying change.
    function automatic outs_t ei(input int cr, input bit rej, input bit err);
        outs_t o = '0;
        o.cfg_ready = (cr == 0); o.coin_reject = rej; o.err_insuff = err; o.credit = 8'(cr);
        return o;
    endfunction

    function automatic outs_t ev(input int pid, input int cr, input bit rej);
        outs_t o = '0;
        o.prod_valid = 1'b1; o.prod_id = 2'(pid); o.busy = 1'b1;
        o.coin_reject = rej; o.credit = 8'(cr);
        return o;
    endfunction

    function automatic outs_t ec(input int code, input int cr, input bit rej);
        outs_t o = '0;
        o.chg_valid = 1'b1; o.chg_coin = 2'(code); o.busy = 1'b1;
        o.coin_reject = rej; o.credit = 8'(cr);
        return o;
    endfunction

    function automatic vec_t v(input bit cv, input int ci, input int cp, input bit kv, input int kc,
                               input bit sv, input int s, input bit cn, input bit rdy, input outs_t e);
        vec_t t;
        t.cfgv = cv; t.idx = 2'(ci); t.price = 8'(cp);
        t.coinv = kv; t.code = 2'(kc);
        t.selv = sv; t.s = 2'(s); t.cnl = cn; t.rdy = rdy; t.exp = e;
        return t;
    endfunction

    function automatic vec_t nop(input bit rdy, input outs_t e);
        return v(0, 0, 0, 0, 0, 0, 0, 0, rdy, e);
    endfunction
    function automatic vec_t cfg(input int i, input int p, input outs_t e);
        return v(1, i, p, 0, 0, 0, 0, 0, 1, e);
    endfunction
    function automatic vec_t coin(input int c, input bit rdy, input outs_t e);
        return v(0, 0, 0, 1, c, 0, 0, 0, rdy, e);
    endfunction
    function automatic vec_t pick(input int s, input outs_t e);
        return v(0, 0, 0, 0, 0, 1, s, 0, 1, e);
    endfunction
    function automatic vec_t cnl(input bit rdy, input outs_t e);
        return v(0, 0, 0, 0, 0, 0, 0, 1, rdy, e);
    endfunction

    task automatic drive(input vec_t t);
        cfg_valid = t.cfgv; cfg_idx = t.idx; cfg_price = t.price;
        coin_valid = t.coinv; coin_code = t.code;
        sel_valid = t.selv; sel = t.s; cancel = t.cnl; chg_ready = t.rdy;
    endtask

    task automatic idle_inputs();
        drive(nop(1'b0, '0));
    endtask

    task automatic step_check(input vec_t t, input string name);
        drive(t);
        @(posedge clk);
        #1;
        check(name, t.exp);
    endtask

    // Reference model: greedy payout plan held as a queue of coin codes.
    task automatic m_plan(input int amount);
        int rem;
        m_pay.delete();
        rem = amount;
        while (rem > 0) begin
            for (int k = 3; k >= 0; k--) begin
                if (denom[k] <= rem) begin
                    m_pay.push_back(k);
                    rem -= denom[k];
                    break;
                end
            end
        end
    endtask

    task automatic m_reset();
        m_mode = M_IDLE; m_credit = 0; m_item = 0;
        m_price = '{0, 0, 0};
        m_rej = 0; m_err = 0;
        m_pay.delete();
    endtask

    task automatic m_step();
        bit took, rej, err;
        int p, cr0;
        took = 0; rej = 0; err = 0; cr0 = m_credit;
        case (m_mode)
            M_IDLE: begin
                if (cancel && cr0 > 0) begin
                    m_plan(cr0); m_mode = M_CHANGE; took = 1;
                end else if (sel_valid && sel != 0) begin
                    p = m_price[int'(sel) - 1];
                    if (p != 0 && cr0 >= p) begin
                        m_item = int'(sel); m_mode = M_VEND; took = 1;
                    end else begin
                        err = 1;
                    end
                end
                if (cfg_valid && cr0 == 0 && cfg_idx != 2'd3) m_price[int'(cfg_idx)] = int'(cfg_price);
                if (coin_valid) begin
                    if (!took && cr0 + denom[coin_code] <= 255) m_credit = cr0 + denom[coin_code];
                    else rej = 1;
                end
            end
            M_VEND: begin
                rej = coin_valid;
                m_credit -= m_price[m_item - 1];
                if (m_credit > 0) begin
                    m_plan(m_credit); m_mode = M_CHANGE;
                end else begin
                    m_mode = M_IDLE;
                end
            end
            default: begin
                rej = coin_valid;
                if (chg_ready) begin
                    m_credit -= denom[m_pay.pop_front()];
                    if (m_pay.size() == 0) m_mode = M_IDLE;
                end
            end
        endcase
        m_rej = rej; m_err = err;
    endtask

    function automatic outs_t m_exp();
        outs_t o = '0;
        o.cfg_ready   = (m_mode == M_IDLE) && (m_credit == 0);
        o.coin_reject = m_rej;
        o.err_insuff  = m_err;
        o.credit      = 8'(m_credit);
        if (m_mode == M_VEND) begin
            o.prod_valid = 1'b1; o.prod_id = 2'(m_item); o.busy = 1'b1;
        end
        if (m_mode == M_CHANGE) begin
            o.chg_valid = 1'b1; o.chg_coin = 2'(m_pay[0]); o.busy = 1'b1;
        end
        return o;
    endfunction

    initial begin
        // Directed table: configure, buy with change, refusal, overflow, combined requests.
        tbl.push_back(cfg(0, 15, ei(0, 0, 0)));
        tbl.push_back(cfg(1, 30, ei(0, 0, 0)));
        tbl.push_back(cfg(2, 99, ei(0, 0, 0)));
        tbl.push_back(cfg(3, 77, ei(0, 0, 0)));
        tbl.push_back(coin(2, 1, ei(10, 0, 0)));
        tbl.push_back(coin(2, 1, ei(20, 0, 0)));
        tbl.push_back(pick(1, ev(1, 20, 0)));
        tbl.push_back(nop(1, ec(1, 5, 0)));
        tbl.push_back(nop(1, ei(0, 0, 0)));
        tbl.push_back(coin(3, 1, ei(50, 0, 0)));
        tbl.push_back(pick(3, ei(50, 0, 1)));
        tbl.push_back(nop(1, ei(50, 0, 0)));
        tbl.push_back(cnl(0, ec(3, 50, 0)));
        tbl.push_back(nop(0, ec(3, 50, 0)));
        tbl.push_back(nop(1, ei(0, 0, 0)));
        tbl.push_back(pick(2, ei(0, 0, 1)));
        tbl.push_back(pick(0, ei(0, 0, 0)));
        tbl.push_back(coin(2, 1, ei(10, 0, 0)));
        tbl.push_back(coin(2, 1, ei(20, 0, 0)));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 0, 1, ev(1, 20, 1)));
        tbl.push_back(nop(1, ec(1, 5, 0)));
        tbl.push_back(nop(1, ei(0, 0, 0)));
        for (int k = 1; k <= 5; k++) tbl.push_back(coin(3, 1, ei(50 * k, 0, 0)));
        tbl.push_back(coin(2, 1, ei(250, 1, 0)));
        tbl.push_back(coin(1, 1, ei(255, 0, 0)));
        tbl.push_back(coin(0, 1, ei(255, 1, 0)));
        tbl.push_back(cnl(1, ec(3, 255, 0)));
        tbl.push_back(nop(1, ec(3, 205, 0)));
        tbl.push_back(nop(1, ec(3, 155, 0)));
        tbl.push_back(nop(1, ec(3, 105, 0)));
        tbl.push_back(nop(1, ec(3, 55, 0)));
        tbl.push_back(nop(1, ec(1, 5, 0)));
        tbl.push_back(nop(1, ei(0, 0, 0)));
        tbl.push_back(coin(2, 1, ei(10, 0, 0)));
        tbl.push_back(coin(2, 1, ei(20, 0, 0)));
        tbl.push_back(coin(2, 1, ei(30, 0, 0)));
        tbl.push_back(coin(1, 1, ei(35, 0, 0)));
        tbl.push_back(coin(0, 1, ei(36, 0, 0)));
        tbl.push_back(coin(0, 1, ei(37, 0, 0)));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 1, 0, ec(2, 37, 1)));
        tbl.push_back(coin(3, 0, ec(2, 37, 1)));
        tbl.push_back(nop(1, ec(2, 27, 0)));
        tbl.push_back(nop(0, ec(2, 27, 0)));
        tbl.push_back(nop(1, ec(2, 17, 0)));
        tbl.push_back(nop(0, ec(2, 17, 0)));
        tbl.push_back(nop(1, ec(1, 7, 0)));
        tbl.push_back(nop(0, ec(1, 7, 0)));
        tbl.push_back(nop(1, ec(0, 2, 0)));
        tbl.push_back(nop(1, ec(0, 1, 0)));
        tbl.push_back(nop(1, ei(0, 0, 0)));

        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", ei(0, 0, 0));
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) step_check(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a payout of 27.
        step_check(coin(2, 1, ei(10, 0, 0)), "r27_c1");
        step_check(coin(2, 1, ei(20, 0, 0)), "r27_c2");
        step_check(coin(1, 1, ei(25, 0, 0)), "r27_c3");
        step_check(coin(0, 1, ei(26, 0, 0)), "r27_c4");
        step_check(coin(0, 1, ei(27, 0, 0)), "r27_c5");
        step_check(cnl(0, ec(2, 27, 0)), "r27_change");
        drive(nop(0, '0));
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_change", ei(0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", ei(0, 0, 0));
        step_check(coin(0, 1, ei(1, 0, 0)), "post_rst_coin");
        step_check(pick(1, ei(1, 0, 1)), "post_rst_price0_item1");
        step_check(pick(3, ei(1, 0, 1)), "post_rst_price0_item3");
        step_check(cnl(1, ec(0, 1, 0)), "post_rst_cancel");
        step_check(nop(1, ei(0, 0, 0)), "post_rst_done");

        // Random traffic against the model.
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            cfg_valid  = ($urandom_range(0, 9) == 0);
            cfg_idx    = 2'($urandom_range(0, 3));
            cfg_price  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 120));
            coin_valid = ($urandom_range(0, 2) == 0);
            coin_code  = 2'($urandom_range(0, 3));
            cancel     = ($urandom_range(0, 29) == 0);
            sel_valid  = !cancel && !coin_valid && ($urandom_range(0, 5) == 0);
            sel        = 2'($urandom_range(0, 3));
            chg_ready  = ($urandom_range(0, 3) != 0);
            check($sformatf("rnd%0d", c), m_exp());
            @(posedge clk);
            m_step();
            #1;
        end
        check("rnd_final", m_exp());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
